// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Encodings double as the externally visible ctrl_state value.
  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StDmemWait = 2'd1,
    StTrapHold = 2'd2
  } ctrl_state_e;

  localparam int unsigned HoldW = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side request signals and controller-side halt/flush/redirect outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_use;
  logic             id_rs2_use;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_valid;
  logic             ex_branch_taken;
  logic [63:0]      ex_target;
  logic             mem_trap;
  logic [63:0]      mem_trap_target;
  logic             imem_busy;
  logic             dmem_busy;

  logic             pc_stall;
  logic             pc_redirect;
  logic [63:0]      pc_target;
  logic             if_id_halt;
  logic             id_ex_halt;
  logic             ex_mem_halt;
  logic             mem_wb_halt;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: raises hazards, consumes control.
  modport master (
    output id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_mem_read, ex_valid,
           ex_branch_taken, ex_target, mem_trap, mem_trap_target, imem_busy, dmem_busy,
    input  pc_stall, pc_redirect, pc_target, if_id_halt, id_ex_halt, ex_mem_halt,
           mem_wb_halt, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, ctrl_state,
           stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_use, id_rs2_use, ex_rd, ex_mem_read, ex_valid,
           ex_branch_taken, ex_target, mem_trap, mem_trap_target, imem_busy, dmem_busy,
    output pc_stall, pc_redirect, pc_target, if_id_halt, id_ex_halt, ex_mem_halt,
           mem_wb_halt, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, ctrl_state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between ID sources and the EX load destination.
module load_use_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  input  logic       ex_valid_i,
  output logic       hazard_o
);

  // x0 never carries a value, so a load to x0 cannot create a dependency.
  always_comb begin
    hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
               ((id_rs1_use_i && (id_rs1_i == ex_rd_i)) ||
                (id_rs2_use_i && (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: freeze FSM, priority mux and saturating event counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_HOLD = 1,
  parameter int unsigned CNT_W         = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [HoldW-1:0] HoldInit = HoldW'(REDIRECT_HOLD);

  ctrl_state_e      state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        hazard;
  logic        in_hold;
  logic        pc_stall, pc_redirect;
  logic [63:0] pc_target;
  logic        if_id_halt, id_ex_halt, ex_mem_halt, mem_wb_halt;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

  load_use_detect u_load_use (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_rs1_use_i  (bus.id_rs1_use),
    .id_rs2_use_i  (bus.id_rs2_use),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_valid_i    (bus.ex_valid),
    .hazard_o      (hazard)
  );

  // Next state and prioritised control outputs; a pending hold count survives a dmem freeze.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    pc_stall     = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    if_id_halt   = 1'b0;
    id_ex_halt   = 1'b0;
    ex_mem_halt  = 1'b0;
    mem_wb_halt  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    in_hold      = (state_q == StTrapHold) || ((state_q == StDmemWait) && (hold_q != '0));

    if (!rst) begin
      // Outputs stay idle while reset is asserted.
    end else if (bus.dmem_busy) begin
      pc_stall    = 1'b1;
      if_id_halt  = 1'b1;
      id_ex_halt  = 1'b1;
      ex_mem_halt = 1'b1;
      mem_wb_halt = 1'b1;
      state_d     = StDmemWait;
    end else begin
      state_d = StRun;
      if (in_hold) begin
        hold_d  = hold_q - 1'b1;
        state_d = (hold_d == '0) ? StRun : StTrapHold;
      end

      if (bus.mem_trap && !in_hold) begin
        pc_redirect  = 1'b1;
        pc_target    = bus.mem_trap_target;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        if (REDIRECT_HOLD > 0) begin
          state_d = StTrapHold;
          hold_d  = HoldInit;
        end
      end else if (bus.ex_branch_taken && bus.ex_valid && !in_hold) begin
        pc_redirect = 1'b1;
        pc_target   = bus.ex_target;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard) begin
        pc_stall    = 1'b1;
        if_id_halt  = 1'b1;
        id_ex_flush = 1'b1;
      end else if (bus.imem_busy) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end

      // Fetch-discard window: IF/ID is thrown away, so the flush overrides any halt.
      if (in_hold) begin
        if_id_flush = 1'b1;
        if_id_halt  = 1'b0;
      end
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if ((if_id_flush || id_ex_flush || ex_mem_flush || mem_wb_flush) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, hold count and counters; reset aborts any freeze or hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      hold_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.pc_redirect  = pc_redirect;
  assign bus.pc_target    = pc_target;
  assign bus.if_id_halt   = if_id_halt;
  assign bus.id_ex_halt   = id_ex_halt;
  assign bus.ex_mem_halt  = ex_mem_halt;
  assign bus.mem_wb_halt  = mem_wb_halt;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.ctrl_state   = state_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REDIRECT_HOLD = 2 main instance, 0 side instance).
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus0 ();

  pipeline_hazard_ctrl #(.REDIRECT_HOLD(2), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pipeline_hazard_ctrl #(.REDIRECT_HOLD(0), .CNT_W(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1 = 5'd0;           bus.id_rs2 = 5'd0;
    bus.id_rs1_use = 1'b0;       bus.id_rs2_use = 1'b0;
    bus.ex_rd = 5'd0;            bus.ex_mem_read = 1'b0;
    bus.ex_valid = 1'b0;         bus.ex_branch_taken = 1'b0;
    bus.ex_target = 64'd0;       bus.mem_trap = 1'b0;
    bus.mem_trap_target = 64'd0; bus.imem_busy = 1'b0;
    bus.dmem_busy = 1'b0;
    bus0.id_rs1 = 5'd0;           bus0.id_rs2 = 5'd0;
    bus0.id_rs1_use = 1'b0;       bus0.id_rs2_use = 1'b0;
    bus0.ex_rd = 5'd0;            bus0.ex_mem_read = 1'b0;
    bus0.ex_valid = 1'b0;         bus0.ex_branch_taken = 1'b0;
    bus0.ex_target = 64'd0;       bus0.mem_trap = 1'b0;
    bus0.mem_trap_target = 64'd0; bus0.imem_busy = 1'b0;
    bus0.dmem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [7:0] halts();
    return {bus.if_id_halt, bus.id_ex_halt, bus.ex_mem_halt, bus.mem_wb_halt,
            bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush};
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #2;
    n_vec++; if (halts() !== 8'h00) begin n_err++; $display("FAIL reset_hf got %h want 00", halts()); end
    n_vec++; if ({bus.pc_stall, bus.pc_redirect} !== 2'b00) begin n_err++; $display("FAIL reset_pc got %b want 00", {bus.pc_stall, bus.pc_redirect}); end
    n_vec++; if (bus.ctrl_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", bus.ctrl_state); end
    n_vec++; if ({bus.stall_cnt, bus.flush_cnt} !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %h want 0", {bus.stall_cnt, bus.flush_cnt}); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_rs1_use = 1'b1;
    #1;
    // order: if_id_h id_ex_h ex_mem_h mem_wb_h if_id_f id_ex_f ex_mem_f mem_wb_f
    n_vec++; if (halts() !== 8'b1000_0100) begin n_err++; $display("FAIL lu_hf got %b want 10000100", halts()); end
    n_vec++; if ({bus.pc_stall, bus.pc_redirect} !== 2'b10) begin n_err++; $display("FAIL lu_pc got %b want 10", {bus.pc_stall, bus.pc_redirect}); end
    tick();
    bus.ex_valid = 1'b0;  // EX now holds the bubble
    #1;
    n_vec++; if (bus.pc_stall !== 1'b0) begin n_err++; $display("FAIL lu_clear got %b want 0", bus.pc_stall); end
    n_vec++; if (bus.stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt got %0d want 1", bus.stall_cnt); end
    // Load to x0 is never a hazard.
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    #1;
    n_vec++; if (bus.pc_stall !== 1'b0) begin n_err++; $display("FAIL lu_x0 got %b want 0", bus.pc_stall); end
    // rs2 path, rs1 unused.
    bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_rs1_use = 1'b0;
    bus.id_rs2 = 5'd9; bus.id_rs2_use = 1'b1;
    #1;
    n_vec++; if (bus.if_id_halt !== 1'b1) begin n_err++; $display("FAIL lu_rs2 got %b want 1", bus.if_id_halt); end
    bus.id_rs2_use = 1'b0;
    #1;
    n_vec++; if (bus.if_id_halt !== 1'b0) begin n_err++; $display("FAIL lu_nouse got %b want 0", bus.if_id_halt); end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_target = 64'h8000_0100;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_use = 1'b1;
    #1;
    n_vec++; if ({bus.pc_stall, bus.pc_redirect} !== 2'b01) begin n_err++; $display("FAIL br_pc got %b want 01", {bus.pc_stall, bus.pc_redirect}); end
    n_vec++; if (bus.pc_target !== 64'h8000_0100) begin n_err++; $display("FAIL br_target got %h want 80000100", bus.pc_target); end
    n_vec++; if (halts() !== 8'b0000_1100) begin n_err++; $display("FAIL br_hf got %b want 00001100", halts()); end
    tick();
    idle();
    #1;
    n_vec++; if (bus.flush_cnt !== 16'd1) begin n_err++; $display("FAIL br_flush_cnt got %0d want 1", bus.flush_cnt); end
    n_vec++; if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL br_stall_cnt got %0d want 0", bus.stall_cnt); end
    // Not-valid EX cannot redirect.
    bus.ex_branch_taken = 1'b1;
    #1;
    n_vec++; if (bus.pc_redirect !== 1'b0) begin n_err++; $display("FAIL br_invalid got %b want 0", bus.pc_redirect); end
    idle();
  endtask

  task automatic test_trap();
    do_reset();
    bus.mem_trap = 1'b1; bus.mem_trap_target = 64'h8000_0000;
    bus.ex_valid = 1'b1; bus.ex_branch_taken = 1'b1; bus.ex_target = 64'h1234;
    #1;
    n_vec++; if (bus.pc_target !== 64'h8000_0000) begin n_err++; $display("FAIL tr_target got %h want 80000000", bus.pc_target); end
    n_vec++; if (bus.pc_redirect !== 1'b1) begin n_err++; $display("FAIL tr_redirect got %b want 1", bus.pc_redirect); end
    n_vec++; if (halts() !== 8'b0000_1110) begin n_err++; $display("FAIL tr_hf got %b want 00001110", halts()); end
    tick();
    bus.mem_trap = 1'b0;  // branch still pulsed: must be ignored in the hold window
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (bus.ctrl_state !== 2'd2) begin n_err++; $display("FAIL tr_hold_state[%0d] got %0d want 2", i, bus.ctrl_state); end
      n_vec++; if (halts() !== 8'b0000_1000) begin n_err++; $display("FAIL tr_hold_hf[%0d] got %b want 00001000", i, halts()); end
      n_vec++; if (bus.pc_redirect !== 1'b0) begin n_err++; $display("FAIL tr_hold_br[%0d] got %b want 0", i, bus.pc_redirect); end
      tick();
    end
    #1;
    n_vec++; if (bus.ctrl_state !== 2'd0) begin n_err++; $display("FAIL tr_end_state got %0d want 0", bus.ctrl_state); end
    n_vec++; if (bus.pc_redirect !== 1'b1) begin n_err++; $display("FAIL tr_end_br got %b want 1", bus.pc_redirect); end
    n_vec++; if (bus.flush_cnt !== 16'd3) begin n_err++; $display("FAIL tr_flush_cnt got %0d want 3", bus.flush_cnt); end
    idle();
  endtask

  task automatic test_dmem_trap();
    do_reset();
    bus.mem_trap = 1'b1; bus.mem_trap_target = 64'h8000_0000; bus.dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (halts() !== 8'b1111_0000) begin n_err++; $display("FAIL dm_hf[%0d] got %b want 11110000", i, halts()); end
      n_vec++; if ({bus.pc_stall, bus.pc_redirect} !== 2'b10) begin n_err++; $display("FAIL dm_pc[%0d] got %b want 10", i, {bus.pc_stall, bus.pc_redirect}); end
      tick();
    end
    bus.dmem_busy = 1'b0;
    #1;
    n_vec++; if (bus.ctrl_state !== 2'd1) begin n_err++; $display("FAIL dm_state got %0d want 1", bus.ctrl_state); end
    n_vec++; if ({bus.pc_redirect, bus.pc_target} !== {1'b1, 64'h8000_0000}) begin n_err++; $display("FAIL dm_trap got %b/%h want 1/80000000", bus.pc_redirect, bus.pc_target); end
    tick();
    bus.mem_trap = 1'b0;
    #1;
    n_vec++; if (bus.stall_cnt !== 16'd4) begin n_err++; $display("FAIL dm_stall_cnt got %0d want 4", bus.stall_cnt); end
    n_vec++; if (bus.ctrl_state !== 2'd2) begin n_err++; $display("FAIL dm_hold got %0d want 2", bus.ctrl_state); end
    // Freeze during the hold keeps the remaining count; leaving it decodes as hold.
    bus.dmem_busy = 1'b1;
    tick();
    bus.dmem_busy = 1'b0;
    #1;
    n_vec++; if (bus.if_id_flush !== 1'b1) begin n_err++; $display("FAIL dm_resume_hold got %b want 1", bus.if_id_flush); end
    idle();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    bus.mem_trap = 1'b1; bus.mem_trap_target = 64'h8000_0000;
    tick();
    bus.mem_trap = 1'b0; bus.imem_busy = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.ctrl_state !== 2'd0) begin n_err++; $display("FAIL rh_state got %0d want 0", bus.ctrl_state); end
    n_vec++; if ({bus.stall_cnt, bus.flush_cnt} !== 32'd0) begin n_err++; $display("FAIL rh_cnt got %h want 0", {bus.stall_cnt, bus.flush_cnt}); end
    n_vec++; if ({halts(), bus.pc_stall, bus.pc_redirect} !== 10'd0) begin n_err++; $display("FAIL rh_out got %b want 0", {halts(), bus.pc_stall, bus.pc_redirect}); end
    n_vec++; if (bus.pc_target !== 64'd0) begin n_err++; $display("FAIL rh_target got %h want 0", bus.pc_target); end
    idle();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_hold_zero();
    do_reset();
    bus0.mem_trap = 1'b1; bus0.mem_trap_target = 64'h8000_0040;
    #1;
    n_vec++; if ({bus0.pc_redirect, bus0.ex_mem_flush} !== 2'b11) begin n_err++; $display("FAIL h0_trap got %b want 11", {bus0.pc_redirect, bus0.ex_mem_flush}); end
    tick();
    bus0.mem_trap = 1'b0;
    #1;
    n_vec++; if ({bus0.ctrl_state, bus0.if_id_flush} !== 3'b000) begin n_err++; $display("FAIL h0_run got %b want 000", {bus0.ctrl_state, bus0.if_id_flush}); end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    bus.imem_busy = 1'b1;
    #1;
    n_vec++; if (halts() !== 8'b0000_1000) begin n_err++; $display("FAIL ib_hf got %b want 00001000", halts()); end
    repeat (65535) tick();
    n_vec++; if (bus.stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got %h want ffff", bus.stall_cnt); end
    repeat (5) tick();
    n_vec++; if (bus.stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", bus.stall_cnt); end
    n_vec++; if (bus.flush_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_flush got %h want ffff", bus.flush_cnt); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_trap();
    test_dmem_trap();
    test_reset_in_hold();
    test_hold_zero();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
